// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Default geometry and the pointer-plus-toggle bundle layout.
package sync_fifo_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_PTR_ADDR = $clog2(DEF_DEPTH);

  // Toggle sits above the index so a plain +1 carries into it on wrap.
  typedef struct packed {
    logic                    toggle;
    logic [DEF_PTR_ADDR-1:0] addr;
  } ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage, one sync write port, one sync read port.
// Ports: clk, clr (async, clears rdata only), we/waddr/wdata, re/raddr/rdata.
module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and error flags.
// Ports: clk_i, clr_i, wr_en_i, wdata_i, rd_en_i, rdata_o, full_o,
//   empty_o, wr_error_o, rd_error_o. With SYNC_FIFO_DEBUG_EN defined:
//   wr_ptr, rd_ptr, wr_toggle_f, rd_toggle_f.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PTR_ADDR = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                rd_en_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                wr_error_o,
  output logic                rd_error_o
`ifdef SYNC_FIFO_DEBUG_EN
  ,
  output logic [PTR_ADDR-1:0] wr_ptr,
  output logic [PTR_ADDR-1:0] rd_ptr,
  output logic                wr_toggle_f,
  output logic                rd_toggle_f
`endif
);

`ifndef SYNC_FIFO_DEBUG_EN
  logic [PTR_ADDR-1:0] wr_ptr;
  logic [PTR_ADDR-1:0] rd_ptr;
  logic                wr_toggle_f;
  logic                rd_toggle_f;
`endif

  typedef struct packed {
    logic                toggle;
    logic [PTR_ADDR-1:0] addr;
  } fifo_ptr_t;

  localparam logic [PTR_ADDR:0] PTR_ONE = 1;

  fifo_ptr_t wr_nxt;
  fifo_ptr_t rd_nxt;
  logic      same_addr;
  logic      do_wr;
  logic      do_rd;

  assign same_addr = (wr_ptr == rd_ptr);
  assign empty_o   = same_addr && (wr_toggle_f == rd_toggle_f);
  assign full_o    = same_addr && (wr_toggle_f != rd_toggle_f);

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Carry out of the index flips the toggle on DEPTH-1 -> 0.
  assign wr_nxt = fifo_ptr_t'({wr_toggle_f, wr_ptr} + PTR_ONE);
  assign rd_nxt = fifo_ptr_t'({rd_toggle_f, rd_ptr} + PTR_ONE);

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_toggle_f <= 1'b0;
      rd_toggle_f <= 1'b0;
      wr_error_o  <= 1'b0;
      rd_error_o  <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr      <= wr_nxt.addr;
        wr_toggle_f <= wr_nxt.toggle;
      end
      if (do_rd) begin
        rd_ptr      <= rd_nxt.addr;
        rd_toggle_f <= rd_nxt.toggle;
      end
      wr_error_o <= wr_en_i && full_o;
      rd_error_o <= rd_en_i && empty_o;
    end
  end

  // A write and a read never hit the same slot in one cycle:
  // that would need the FIFO to be both not-full and not-empty
  // with equal indices, which the toggle rules out.
  sync_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (PTR_ADDR)
  ) u_mem (
    .clk  (clk_i),
    .clr  (clr_i),
    .we   (do_wr),
    .waddr(wr_ptr),
    .wdata(wdata_i),
    .re   (do_rd),
    .raddr(rd_ptr),
    .rdata(rdata_o)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DEPTH=16, WIDTH=8).
// Expected words queued on accepted writes, popped on accepted reads.
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int PA    = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             clr_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             full_o;
  logic             empty_o;
  logic             wr_error_o;
  logic             rd_error_o;
`ifdef SYNC_FIFO_DEBUG_EN
  logic [PA-1:0]    wr_ptr;
  logic [PA-1:0]    rd_ptr;
  logic             wr_toggle_f;
  logic             rd_toggle_f;
`endif

  sync_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .PTR_ADDR(PA)
  ) dut (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .wr_en_i    (wr_en_i),
    .wdata_i    (wdata_i),
    .rd_en_i    (rd_en_i),
    .rdata_o    (rdata_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .wr_error_o (wr_error_o),
    .rd_error_o (rd_error_o)
`ifdef SYNC_FIFO_DEBUG_EN
    ,
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .wr_toggle_f(wr_toggle_f),
    .rd_toggle_f(rd_toggle_f)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] last_rd;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; checks flags before and
  // everything the edge produces after.
  task automatic cycle(
    input logic             wr,
    input logic [WIDTH-1:0] d,
    input logic             rd
  );
    bit pre_full;
    bit pre_empty;
    pre_full  = (sb.size() == DEPTH);
    pre_empty = (sb.size() == 0);
    wr_en_i = wr;
    wdata_i = d;
    rd_en_i = rd;
    check("pre_full", full_o, pre_full);
    check("pre_empty", empty_o, pre_empty);
    @(posedge clk_i);
    #1;
    if (rd && !pre_empty) last_rd = sb.pop_front();
    if (wr && !pre_full) sb.push_back(d);
    check("rdata", rdata_o, last_rd);
    check("wr_error", wr_error_o, wr && pre_full);
    check("rd_error", rd_error_o, rd && pre_empty);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, WIDTH'($urandom), 1'b0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clr_i   = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    wdata_i = '0;
    last_rd = '0;
    #30;
    clr_i = 1'b0;
    #1;
    // 1 reset state
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_wr_err", wr_error_o, 0);
    check("rst_rd_err", rd_error_o, 0);
    @(posedge clk_i);
    #1;

    // 2 fill to full
    writes(DEPTH);
    check("t2_full", full_o, 1);
    check("t2_empty", empty_o, 0);
    // 3 drain in order
    reads(DEPTH);
    check("t3_empty", empty_o, 1);

    // 3 again on fresh data
    writes(DEPTH);
    reads(DEPTH);

    // 4 overflow: three rejected writes
    writes(DEPTH + 3);
    reads(DEPTH);

    // 5 underflow: three rejected reads, rdata holds
    writes(DEPTH);
    reads(DEPTH + 3);

    // 6 simultaneous traffic across the wrap
    writes(10);
    reads(10);
    writes(4);
    for (int i = 0; i < 12; i++) cycle(1'b1, WIDTH'($urandom), 1'b1);
    check("t6_occ", {27'd0, full_o, empty_o}, 0);
    reads(4);
    check("t6_empty", empty_o, 1);

    // simultaneous while empty / while full
    cycle(1'b1, 8'hA5, 1'b1);
    writes(DEPTH - 1);
    cycle(1'b1, 8'h5A, 1'b1);
    reads(DEPTH - 1);

    // async reset mid-operation discards contents
    writes(5);
    #2;
    clr_i = 1'b1;
    #1;
    check("arst_empty", empty_o, 1);
    check("arst_rdata", rdata_o, 0);
    sb.delete();
    last_rd = '0;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    reads(1);
    writes(3);
    reads(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
